// File: rtl/fpu_rnd_sched_pkg.sv
// Shared constants and operand/result types for the FPU rounding scheduler,
// its rounder and the producers that feed it.
package fpu_rnd_pkg;

    localparam int NREQ_D    = 3;
    localparam int OPW_D     = 72;
    localparam int RESW_D    = 64;
    localparam int RND_LAT_D = 2;
    localparam int DEPTH_D   = 4;

    function automatic int tagWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [tagWidth(NREQ_D)-1:0] tag_t;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rmode_e;

    // Significand carries guard/round bits ahead of rounding.
    typedef struct packed {
        logic        sign;
        logic [10:0] exp;
        logic [54:0] sig;
        rmode_e      rm;
        logic        db;
        logic        ovfEn;
    } rnd_op_t;

    typedef struct packed {
        logic        sign;
        logic [10:0] exp;
        logic [51:0] frac;
    } rnd_res_t;

endpackage

// File: rtl/fpu_rnd_sched_if.sv
// Producer, rounder and consumer signals of the rounding scheduler;
// the scheduler connects through the slave modport.
interface fpu_rnd_sched_if #(
    parameter int NREQ = 3,
    parameter int OPW  = 72,
    parameter int RESW = 64,
    parameter int TW   = 2
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*OPW-1:0] req_op;
    logic                rnd_valid;
    logic [OPW-1:0]      rnd_op;
    logic [RESW-1:0]     rnd_res;
    logic                res_valid;
    logic                res_ready;
    logic [RESW-1:0]     res_data;
    logic [TW-1:0]       res_tag;

    modport master (
        output req_valid, req_op, rnd_res, res_ready,
        input  req_ready, rnd_valid, rnd_op, res_valid, res_data, res_tag
    );

    modport slave (
        input  req_valid, req_op, rnd_res, res_ready,
        output req_ready, rnd_valid, rnd_op, res_valid, res_data, res_tag
    );
endinterface

// File: rtl/fpu_rnd_sched_rr_arb.sv
// Round-robin arbiter: searches upward from i_ptr+1 with wrap and returns
// a one-hot grant plus the granted index.
module rnd_rr_arb
    import fpu_rnd_pkg::*;
#(
    parameter int N  = 3,
    parameter int TW = tagWidth(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [TW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [TW-1:0] o_idx
);
    int   w_cand;
    logic w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int k = 1; k <= N; k++) begin
            w_cand = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[w_cand]) begin
                w_found       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = TW'(w_cand);
            end
        end
    end
endmodule

// File: rtl/fpu_rnd_sched.sv
// Shares one fixed-latency rounder among NREQ producers with credit-limited issue
// and an in-order tagged result FIFO. Define FPU_RND_PRIO_EN to give requester 0 absolute priority.
module fpu_rnd_sched
    import fpu_rnd_pkg::*;
#(
    parameter int NREQ    = NREQ_D,
    parameter int OPW     = OPW_D,
    parameter int RESW    = RESW_D,
    parameter int RND_LAT = RND_LAT_D,
    parameter int DEPTH   = DEPTH_D,
    localparam int TW     = tagWidth(NREQ)
) (
    input logic            clk,
    input logic            rst,
    fpu_rnd_sched_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [TW-1:0]   r_ptr;
    logic [CW-1:0]   r_occ;
    logic            r_rndValid;
    logic [OPW-1:0]  r_rndOp;
    logic [TW-1:0]   r_issueTag;
    logic [RND_LAT-1:0] r_pipeValid;
    logic [TW-1:0]   r_pipeTag [RND_LAT];
    logic [RESW-1:0] r_fifoData [DEPTH];
    logic [TW-1:0]   r_fifoTag [DEPTH];
    logic [PW-1:0]   r_wrPtr;
    logic [PW-1:0]   r_rdPtr;
    logic [CW-1:0]   r_fifoCnt;

    logic [NREQ-1:0] w_arbReq;
    logic [NREQ-1:0] w_arbGnt;
    logic [TW-1:0]   w_arbIdx;
    logic [NREQ-1:0] w_gnt;
    logic [TW-1:0]   w_idx;
    logic [OPW-1:0]  w_opSel;
    logic            w_allow;
    logic            w_hs;
    logic            w_ptrUpd;
    logic            w_push;
    logic            w_pop;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef FPU_RND_PRIO_EN
    assign w_arbReq = bus.req_valid & ~NREQ'(1);
    assign w_ptrUpd = w_hs && !bus.req_valid[0];
`else
    assign w_arbReq = bus.req_valid;
    assign w_ptrUpd = w_hs;
`endif

    rnd_rr_arb #(.N(NREQ), .TW(TW)) u_arb (
        .i_req (w_arbReq),
        .i_ptr (r_ptr),
        .o_gnt (w_arbGnt),
        .o_idx (w_arbIdx)
    );

    // A full credit pool blocks issue even when a pop is happening this cycle.
    assign w_allow = (r_occ < CW'(DEPTH)) && !rst;

    always_comb begin
        w_gnt = w_arbGnt;
        w_idx = w_arbIdx;
`ifdef FPU_RND_PRIO_EN
        if (bus.req_valid[0]) begin
            w_gnt = NREQ'(1);
            w_idx = '0;
        end
`endif
        if (!w_allow) begin
            w_gnt = '0;
        end
    end

    assign w_hs          = |(bus.req_valid & w_gnt);
    assign w_opSel       = bus.req_op[w_idx*OPW +: OPW];
    assign w_push        = r_pipeValid[RND_LAT-1];
    assign w_pop         = (r_fifoCnt != '0) && bus.res_ready;

    assign bus.req_ready = w_gnt;
    assign bus.rnd_valid = r_rndValid;
    assign bus.rnd_op    = r_rndOp;
    assign bus.res_valid = (r_fifoCnt != '0);
    assign bus.res_data  = bus.res_valid ? r_fifoData[r_rdPtr] : '0;
    assign bus.res_tag   = bus.res_valid ? r_fifoTag[r_rdPtr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rndValid <= 1'b0;
            r_rndOp    <= '0;
            r_issueTag <= '0;
            r_ptr      <= TW'(NREQ - 1);
            r_occ      <= '0;
        end else begin
            r_rndValid <= w_hs;
            if (w_hs) begin
                r_rndOp    <= w_opSel;
                r_issueTag <= w_idx;
            end
            if (w_ptrUpd) begin
                r_ptr <= w_idx;
            end
            if (w_hs && !w_pop) begin
                r_occ <= r_occ + 1'b1;
            end else if (!w_hs && w_pop) begin
                r_occ <= r_occ - 1'b1;
            end
        end
    end

    // Tag pipe mirrors the rounder so the last stage lines up with rnd_res.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipeValid <= '0;
            for (int i = 0; i < RND_LAT; i++) begin
                r_pipeTag[i] <= '0;
            end
        end else begin
            r_pipeValid[0] <= r_rndValid;
            r_pipeTag[0]   <= r_issueTag;
            for (int i = 1; i < RND_LAT; i++) begin
                r_pipeValid[i] <= r_pipeValid[i-1];
                r_pipeTag[i]   <= r_pipeTag[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_fifoCnt <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            if (w_push && !w_pop) begin
                r_fifoCnt <= r_fifoCnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_fifoCnt <= r_fifoCnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_fifoData[r_wrPtr] <= bus.rnd_res;
            r_fifoTag[r_wrPtr]  <= r_pipeTag[RND_LAT-1];
        end
    end
endmodule
